// File: rtl/nv_fifo_rwsp_61x64_ctrl.sv
// nv_fifo_rwsp_61x64_ctrl
//
// Valid/ready FIFO controller wrapped around a 61x64 two-port RAM. The RAM
// read takes two cycles: the read address is registered, then the output
// register. A 3-entry output skid absorbs that latency so the block sustains
// one word per cycle in and out, in order, under arbitrary backpressure.
//
// Ports
//   nvdla_core_clk   core clock, all logic on posedge
//   nvdla_core_rstn  asynchronous active-low reset
//   wr_pvld/wr_prdy  producer handshake, wr_pd payload
//   rd_pvld/rd_prdy  consumer handshake, rd_pd payload (skid head)
//   ram_we/wa/di     RAM write port
//   ram_re/ra        RAM read-address capture (stage 1)
//   ram_ore          RAM output-register enable (stage 2)
//   ram_dout         RAM registered output, valid the cycle after ram_ore
//   pwrbus_ram_pd    RAM power control, owned by the RAM; unused here
module nv_fifo_rwsp_61x64_ctrl #(
   parameter int DEPTH = 61,
   parameter int WIDTH = 64,
   parameter int AW    = 6,
   parameter int SKID  = 3
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [WIDTH-1:0] wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [WIDTH-1:0] rd_pd,
   output logic             ram_we,
   output logic [AW-1:0]    ram_wa,
   output logic [WIDTH-1:0] ram_di,
   output logic             ram_re,
   output logic [AW-1:0]    ram_ra,
   output logic             ram_ore,
   input  logic [WIDTH-1:0] ram_dout,
   input  logic [31:0]      pwrbus_ram_pd
);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [6:0]       ram_used;
   logic [6:0]       avail;
   logic             s1_vld;
   logic             s2_vld;
   logic [1:0]       skid_cnt;
   logic [1:0]       skid_head;
   logic [1:0]       skid_tail;
   logic [WIDTH-1:0] skid_mem [SKID];
   logic             rst_done;
   logic             wr_acc;
   logic             issue;
   logic             pop;
   logic             capture;
   logic [2:0]       occ_after_pop;
   logic             unused_pwrbus;

   // RAM pointers wrap at DEPTH-1, which is not a power of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   function automatic logic [1:0] skid_inc(input logic [1:0] i);
      return (i == 2'(SKID - 1)) ? 2'd0 : i + 2'd1;
   endfunction

   // The power bus belongs to the RAM macro; it is only folded here so it is
   // visibly consumed.
   assign unused_pwrbus = ^pwrbus_ram_pd;

   // Handshake and pipeline control. rst_done keeps wr_prdy low for the whole
   // time reset is asserted even though ram_used is already zero. A read is
   // issued only when the skid is guaranteed a slot for it: every read in
   // flight already owns a slot, and a pop this cycle frees one.
   assign wr_prdy       = rst_done && (ram_used < 7'(DEPTH));
   assign wr_acc        = wr_pvld && wr_prdy;
   assign rd_pvld       = (skid_cnt != 2'd0);
   assign pop           = rd_pvld && rd_prdy;
   assign capture       = s2_vld;
   assign occ_after_pop = {2'b00, s1_vld} + {2'b00, s2_vld}
                        + {1'b0, skid_cnt} - {2'b00, pop};
   assign issue         = (avail != 7'd0) && (occ_after_pop < 3'(SKID));

   // RAM port drive. The output register is enabled one cycle after the
   // address capture, and its data lands in the skid the cycle after that.
   assign ram_we  = wr_acc;
   assign ram_wa  = wr_ptr;
   assign ram_di  = wr_pd;
   assign ram_re  = issue;
   assign ram_ra  = rd_ptr;
   assign ram_ore = s1_vld;
   assign rd_pd   = skid_mem[skid_head];

   // Write/read pointers and occupancy counters. ram_used only drops at the
   // end of the output-register cycle, so a location cannot be rewritten
   // while its word is still travelling through the RAM. avail counts
   // entries whose write edge has passed but that have not been issued.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         rst_done <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_used <= '0;
         avail    <= '0;
      end else begin
         rst_done <= 1'b1;
         if (wr_acc) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (issue) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         ram_used <= ram_used + 7'(wr_acc) - 7'(s1_vld);
         avail    <= avail + 7'(wr_acc) - 7'(issue);
      end
   end

   // Read pipeline stage valids and skid bookkeeping. Capture and pop are
   // independent and may happen in the same cycle.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         s1_vld    <= 1'b0;
         s2_vld    <= 1'b0;
         skid_cnt  <= '0;
         skid_head <= '0;
         skid_tail <= '0;
      end else begin
         s1_vld   <= issue;
         s2_vld   <= s1_vld;
         skid_cnt <= skid_cnt + 2'(capture) - 2'(pop);
         if (capture) begin
            skid_tail <= skid_inc(skid_tail);
         end
         if (pop) begin
            skid_head <= skid_inc(skid_head);
         end
      end
   end

   // Skid payload storage needs no reset; skid_cnt decides what is valid.
   always_ff @(posedge nvdla_core_clk) begin
      if (capture) begin
         skid_mem[skid_tail] <= ram_dout;
      end
   end

   // Occupancy must never exceed the RAM depth and the skid must never be
   // written while full without a simultaneous pop.
   a_no_overflow : assert property (
      @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
      (ram_used <= 7'(DEPTH)) &&
      !(capture && !pop && (skid_cnt == 2'(SKID)))
   );

endmodule

// File: tb/tb_nv_fifo_rwsp_61x64_ctrl.sv
// tb_nv_fifo_rwsp_61x64_ctrl
//
// Self-checking bench for nv_fifo_rwsp_61x64_ctrl. A behavioural model of the
// 61x64 RAM (registered address, registered output) sits on the RAM ports.
// Accepted writes are pushed into an expected-data queue; a monitor pops and
// compares whenever the DUT hands a word to the consumer. Directed phases
// cover reset, latency, streaming, fill/drain and reset with traffic in
// flight; a random phase exercises pointer wrap under random backpressure.
module tb_nv_fifo_rwsp_61x64_ctrl;

   localparam int DEPTH = 61;
   localparam int WIDTH = 64;
   localparam int AW    = 6;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             wr_pvld = 1'b0;
   logic             wr_prdy;
   logic [WIDTH-1:0] wr_pd = '0;
   logic             rd_pvld;
   logic             rd_prdy = 1'b0;
   logic [WIDTH-1:0] rd_pd;
   logic             ram_we;
   logic [AW-1:0]    ram_wa;
   logic [WIDTH-1:0] ram_di;
   logic             ram_re;
   logic [AW-1:0]    ram_ra;
   logic             ram_ore;
   logic [WIDTH-1:0] ram_dout;
   logic [31:0]      pwrbus_ram_pd = 32'h0;

   int vectors = 0;
   int errors = 0;
   int cyc = 0;
   int acc_count = 0;
   int out_count = 0;
   int first_out_cyc = 0;
   int last_out_cyc = 0;
   int wa_wraps = 0;
   int ra_wraps = 0;
   int last_wa = 0;
   int last_ra = 0;
   bit chk_cap = 1'b0;
   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] exp_word;

   always #5 clk = ~clk;

   nv_fifo_rwsp_61x64_ctrl dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .wr_pvld        (wr_pvld),
      .wr_prdy        (wr_prdy),
      .wr_pd          (wr_pd),
      .rd_pvld        (rd_pvld),
      .rd_prdy        (rd_prdy),
      .rd_pd          (rd_pd),
      .ram_we         (ram_we),
      .ram_wa         (ram_wa),
      .ram_di         (ram_di),
      .ram_re         (ram_re),
      .ram_ra         (ram_ra),
      .ram_ore        (ram_ore),
      .ram_dout       (ram_dout),
      .pwrbus_ram_pd  (pwrbus_ram_pd)
   );

   // Behavioural two-cycle RAM: address captured on ram_re, output register
   // loaded from the captured address on ram_ore. A write in the same edge
   // as an output-register load does not bypass into it.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ra_q = '0;
   logic [WIDTH-1:0] dout_q = '0;
   assign ram_dout = dout_q;

   always @(posedge clk) begin
      if (ram_ore) dout_q <= (int'(ra_q) < DEPTH) ? mem[ra_q] : 'x;
      if (ram_re) ra_q <= ram_ra;
      if (ram_we && int'(ram_wa) < DEPTH) mem[ram_wa] <= ram_di;
   end

   // Free-running cycle index used for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
      vectors++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
      end
   endtask

   task automatic apply_stimulus(input logic vld, input logic [63:0] data,
                                 input logic rdy);
      @(posedge clk);
      #1;
      wr_pvld = vld;
      wr_pd   = data;
      rd_prdy = rdy;
   endtask

   // Monitor and scoreboard, sampled on the falling edge. Pops are compared
   // against the expected queue before this cycle's accepted write is pushed.
   // Capacity is checked from the model's word count: fewer than DEPTH words
   // stored means the RAM cannot be full; 64 stored means it must be.
   always @(negedge clk) begin
      if (rstn) begin
         if (chk_cap) begin
            if (exp_q.size() < DEPTH) check_output("wr_prdy below capacity", wr_prdy, 1);
            if (exp_q.size() >= 64) check_output("wr_prdy at capacity", wr_prdy, 0);
         end
         check_output("ram_we handshake", ram_we, wr_pvld && wr_prdy);
         if (rd_pvld && rd_prdy) begin
            if (exp_q.size() == 0) begin
               check_output("rd_pd unexpected word", 1, 0);
            end else begin
               exp_word = exp_q.pop_front();
               check_output("rd_pd data", rd_pd, exp_word);
            end
            out_count++;
            if (out_count == 1) first_out_cyc = cyc;
            last_out_cyc = cyc;
         end
         if (wr_pvld && wr_prdy) begin
            exp_q.push_back(wr_pd);
            acc_count++;
            check_output("ram_di", ram_di, wr_pd);
         end
         if (ram_we) begin
            check_output("ram_wa range", 64'(int'(ram_wa) < DEPTH), 1);
            if (last_wa == DEPTH - 1 && ram_wa == '0) wa_wraps++;
            last_wa = int'(ram_wa);
         end
         if (ram_re) begin
            check_output("ram_ra range", 64'(int'(ram_ra) < DEPTH), 1);
            if (last_ra == DEPTH - 1 && ram_ra == '0) ra_wraps++;
            last_ra = int'(ram_ra);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_output({tag, " wr_prdy"}, wr_prdy, 0);
      check_output({tag, " rd_pvld"}, rd_pvld, 0);
      check_output({tag, " ram_we"}, ram_we, 0);
      check_output({tag, " ram_re"}, ram_re, 0);
      check_output({tag, " ram_ore"}, ram_ore, 0);
   endtask

   // One word into an empty FIFO must appear four cycles later, then the
   // output goes idle again. Data is compared by the monitor.
   task automatic run_single(input logic [63:0] data, input string tag);
      int t_wr;
      int k;
      apply_stimulus(1'b1, data, 1'b1);
      t_wr = cyc;
      apply_stimulus(1'b0, '0, 1'b1);
      k = 0;
      while (!rd_pvld && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_output({tag, " latency"}, 64'(cyc - t_wr), 4);
      @(negedge clk);
      check_output({tag, " rd_pvld after"}, rd_pvld, 0);
   endtask

   task automatic wait_outputs(input int n, input int limit, input string name);
      int k;
      k = 0;
      while (out_count < n && k < limit) begin
         @(negedge clk);
         k++;
      end
      check_output(name, 64'(out_count), 64'(n));
   endtask

   task automatic wait_empty(input int limit, input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      repeat (6) @(negedge clk);
      check_output(name, 64'(exp_q.size()), 0);
   endtask

   // Main sequence of directed and random phases.
   initial begin
      int stall;
      int t0;
      int low_run;
      int k;
      int acc_base;
      int wa_base;
      int ra_base;

      // Reset held from time zero with a write request pending.
      wr_pvld = 1'b1;
      #2;
      check_reset_outputs("initial reset");
      wr_pvld = 1'b0;
      #21 rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("idle rd_pvld", rd_pvld, 0);
      check_output("idle wr_prdy", wr_prdy, 1);

      run_single(64'hA5A5_0000_0000_0001, "single");

      // Streaming: one write per cycle with the consumer always ready.
      out_count = 0;
      stall = 0;
      t0 = 0;
      for (int i = 0; i < 200; i++) begin
         apply_stimulus(1'b1, 64'h1000 + 64'(i), 1'b1);
         if (i == 0) t0 = cyc;
         @(negedge clk);
         if (!wr_prdy) stall++;
      end
      apply_stimulus(1'b0, '0, 1'b1);
      wait_outputs(200, 300, "stream output count");
      check_output("stream wr_prdy stalls", 64'(stall), 0);
      check_output("stream first latency", 64'(first_out_cyc - t0), 4);
      check_output("stream bubbles", 64'(last_out_cyc - first_out_cyc), 199);
      wait_empty(50, "stream leftover words");

      // Fill with the consumer stalled until wr_prdy stays low.
      acc_base = acc_count;
      low_run = 0;
      k = 0;
      while (low_run < 8 && k < 300) begin
         apply_stimulus(1'b1, 64'(acc_count - acc_base), 1'b0);
         @(negedge clk);
         if (wr_prdy) low_run = 0;
         else low_run++;
         k++;
      end
      check_output("fill accepted", 64'(acc_count - acc_base), 64);
      check_output("fill wr_prdy", wr_prdy, 0);

      // Drain: the first pop issues a read whose RAM slot frees two cycles on.
      out_count = 0;
      apply_stimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      check_output("drain wr_prdy first pop", wr_prdy, 0);
      apply_stimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      check_output("drain wr_prdy ore cycle", wr_prdy, 0);
      apply_stimulus(1'b0, '0, 1'b1);
      @(negedge clk);
      check_output("drain wr_prdy freed", wr_prdy, 1);
      wait_outputs(64, 200, "drain output count");
      wait_empty(50, "drain leftover words");

      // Random traffic with 50% valid/ready to wrap both pointers repeatedly.
      chk_cap = 1'b1;
      acc_base = acc_count;
      wa_base = wa_wraps;
      ra_base = ra_wraps;
      k = 0;
      while (acc_count - acc_base < 500 && k < 10000) begin
         apply_stimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                        1'($urandom_range(0, 1)));
         k++;
      end
      check_output("random accepted", 64'(acc_count - acc_base >= 500), 1);
      apply_stimulus(1'b0, '0, 1'b1);
      wait_empty(200, "random leftover words");
      chk_cap = 1'b0;
      check_output("write pointer wraps", 64'(wa_wraps - wa_base >= 5), 1);
      check_output("read pointer wraps", 64'(ra_wraps - ra_base >= 5), 1);

      // Reset with 30 words queued and reads in flight.
      for (int i = 0; i < 30; i++) begin
         apply_stimulus(1'b1, 64'hBEEF_0000 + 64'(i), 1'b0);
      end
      apply_stimulus(1'b1, 64'hBEEF_1000, 1'b1);
      apply_stimulus(1'b1, 64'hBEEF_1001, 1'b1);
      #2 rstn = 1'b0;
      #1;
      check_reset_outputs("mid reset");
      exp_q.delete();
      wr_pvld = 1'b0;
      rd_prdy = 1'b0;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("post reset rd_pvld", rd_pvld, 0);
      check_output("post reset wr_prdy", wr_prdy, 1);
      run_single(64'h5A5A_FFFF_0000_1234, "post reset single");
      wait_empty(20, "post reset leftover words");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
